// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU widths, result-drain state encoding and element offset helper
package tpu_pkg;

    localparam int TPU_N     = 2;
    localparam int TPU_W     = 8;
    // Products of two TPU_W operands plus carry headroom for the accumulation chain.
    localparam int TPU_ACC_W = 2 * TPU_W + 4;
    localparam int TPU_OUT_W = 8;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    function automatic int elem_offset(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/tpu_requant.sv
// rtl/tpu_requant.sv - arithmetic right shift then saturate (TPU_RESULT_SAT_EN) or wrap to OUT_W bits
module tpu_requant import tpu_pkg::*; #(
    parameter int ACC_W = TPU_ACC_W,
    parameter int OUT_W = TPU_OUT_W
) (
    input  logic [ACC_W-1:0] x,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] y,
    output logic             sat
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        if (32'(shift) >= ACC_W) begin
            shifted = {ACC_W{x[ACC_W-1]}};
        end else begin
            shifted = $signed(x) >>> shift;
        end
    end

`ifdef TPU_RESULT_SAT_EN
    // Value fits in OUT_W bits only if every bit from OUT_W-1 upward matches the sign.
    logic [ACC_W-OUT_W:0] hi;
    assign hi = shifted[ACC_W-1:OUT_W-1];

    always_comb begin
        sat = !((&hi) || !(|hi));
        if (!sat) begin
            y = shifted[OUT_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            y = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            y = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted;
    assign y   = shifted[OUT_W-1:0];
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/tpu_result_drain.sv
// rtl/tpu_result_drain.sv - captures the accumulator matrix and streams requantized elements row-major; TPU_RESULT_SAT_EN selects saturation
module tpu_result_drain import tpu_pkg::*; #(
    parameter int N     = TPU_N,
    parameter int ACC_W = TPU_ACC_W,
    parameter int OUT_W = TPU_OUT_W,
    parameter int IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   c_valid,
    input  logic [N*N*ACC_W-1:0]   C_flat,
    input  logic [4:0]             cfg_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   out_sat,
    output logic                   busy,
    output logic                   overrun
);

    localparam int               NE       = N * N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

    rd_state_e           state;
    rd_state_e           state_nxt;
    logic [NE*ACC_W-1:0] mat;
    logic [4:0]          shift_q;
    logic [IDX_W-1:0]    idx;
    logic                overrun_q;

    logic                streaming;
    logic                handshake;
    logic                final_beat;
    logic                capture;
    logic [ACC_W-1:0]    elem [NE];
    logic [OUT_W-1:0]    rq_data;
    logic                rq_sat;

    assign streaming  = (state == RD_STREAM);
    assign handshake  = streaming && out_ready;
    assign final_beat = handshake && (idx == LAST_IDX);
    // A new matrix is taken when idle, or seamlessly on the last beat of the current one.
    assign capture    = c_valid && (!streaming || final_beat);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign elem[elem_offset(r, c, N)] = mat[elem_offset(r, c, N)*ACC_W +: ACC_W];
        end
    end

    tpu_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .x     (elem[idx]),
        .shift (shift_q),
        .y     (rq_data),
        .sat   (rq_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (c_valid) state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (final_beat && !c_valid) state_nxt = RD_IDLE;
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat       <= '0;
            shift_q   <= '0;
            idx       <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= c_valid && streaming && !final_beat;
            if (capture) begin
                mat     <= C_flat;
                shift_q <= cfg_shift;
                idx     <= '0;
            end else if (handshake) begin
                idx <= final_beat ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        out_valid = streaming;
        busy      = streaming;
        out_data  = streaming ? rq_data : '0;
        out_idx   = streaming ? idx : '0;
        out_last  = streaming && (idx == LAST_IDX);
        out_sat   = streaming && rq_sat;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// tb/tb_tpu_result_drain.sv - directed and randomized checks of tpu_result_drain against a queue-based model
module tb_tpu_result_drain;

    localparam int N     = 2;
    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int IDX_W = 2;
    localparam int NE    = N * N;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 c_valid;
    logic [NE*ACC_W-1:0]  C_flat;
    logic [4:0]           cfg_shift;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 out_sat;
    logic                 busy;
    logic                 overrun;

    tpu_result_drain #(
        .N     (N),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_valid   (c_valid),
        .C_flat    (C_flat),
        .cfg_shift (cfg_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        bit last;
        bit sat;
    } beat_t;

    beat_t q[$];
    bit    exp_ovr;
    int    cm[NE];
    int    n_checks;
    int    n_pass;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int requant(input int x, input int sh, output bit sat);
        int y;
        y   = (sh >= ACC_W) ? ((x < 0) ? -1 : 0) : (x >>> sh);
        sat = 1'b0;
`ifdef TPU_RESULT_SAT_EN
        if (y > 127) begin
            y = 127;
            sat = 1'b1;
        end else if (y < -128) begin
            y = -128;
            sat = 1'b1;
        end
`else
        y = y & 255;
        if (y > 127) y = y - 256;
`endif
        return y;
    endfunction

    task automatic set_matrix(input int a, input int b, input int c, input int d);
        int tmp;
        cm[0] = a; cm[1] = b; cm[2] = c; cm[3] = d;
        for (int k = 0; k < NE; k++) begin
            tmp = cm[k];
            C_flat[k*ACC_W +: ACC_W] = tmp[ACC_W-1:0];
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, q.size() > 0);
        check("busy", busy, q.size() > 0);
        check("overrun", overrun, exp_ovr);
        if (q.size() > 0) begin
            check("out_data", $signed(out_data), q[0].data);
            check("out_idx", out_idx, q[0].idx);
            check("out_last", out_last, q[0].last);
            check("out_sat", out_sat, q[0].sat);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input bit cv, input bit rdy);
        bit    hs;
        bit    accepted;
        beat_t b;
        c_valid   = cv;
        out_ready = rdy;
        hs = (q.size() > 0) && rdy;
        if (hs) void'(q.pop_front());
        accepted = cv && (q.size() == 0);
        exp_ovr  = cv && !accepted;
        if (accepted) begin
            for (int k = 0; k < NE; k++) begin
                b.data = requant(cm[k], int'(cfg_shift), b.sat);
                b.idx  = k;
                b.last = (k == NE - 1);
                q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        check_outputs();
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1);
    endtask

    initial begin
        int v;
        n_checks  = 0;
        n_pass    = 0;
        exp_ovr   = 1'b0;
        rst_n     = 1'b0;
        c_valid   = 1'b0;
        out_ready = 1'b0;
        cfg_shift = '0;
        C_flat    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Basic stream
        set_matrix(1, 2, 3, 4);
        cfg_shift = 5'd0;
        step(1'b1, 1'b1);
        for (int k = 0; k < NE; k++) begin
            check("basic_data", $signed(out_data), k + 1);
            check("basic_idx", out_idx, k);
            check("basic_last", out_last, k == NE - 1);
            step(1'b0, 1'b1);
        end
        check("basic_busy_end", busy, 0);
        check("basic_valid_end", out_valid, 0);

        // Backpressure with ready toggling 1,0,0,1,...
        set_matrix(9, -9, 100, -100);
        step(1'b1, 1'b1);
        for (int k = 0; k < 16; k++) step(1'b0, (k % 3) != 1 && (k % 3) != 2 ? 1'b1 : 1'b0);
        drain();

        // Shift
        set_matrix(1000, -1000, 7, -7);
        cfg_shift = 5'd3;
        step(1'b1, 1'b1);
        cfg_shift = 5'd0;
        check("shift_0", $signed(out_data), 125);
        step(1'b0, 1'b1);
        check("shift_1", $signed(out_data), -125);
        step(1'b0, 1'b1);
        check("shift_2", $signed(out_data), 0);
        step(1'b0, 1'b1);
        check("shift_3", $signed(out_data), -1);
        drain();

        // Saturation / wrap
        set_matrix(300, -300, 127, -128);
        cfg_shift = 5'd0;
        step(1'b1, 1'b1);
`ifdef TPU_RESULT_SAT_EN
        check("sat_d0", $signed(out_data), 127);  check("sat_s0", out_sat, 1);
        step(1'b0, 1'b1);
        check("sat_d1", $signed(out_data), -128); check("sat_s1", out_sat, 1);
`else
        check("wrap_d0", $signed(out_data), 44);  check("wrap_s0", out_sat, 0);
        step(1'b0, 1'b1);
        check("wrap_d1", $signed(out_data), -44); check("wrap_s1", out_sat, 0);
`endif
        step(1'b0, 1'b1);
        check("sat_d2", $signed(out_data), 127);
        step(1'b0, 1'b1);
        check("sat_d3", $signed(out_data), -128);
        check("sat_s3", out_sat, 0);
        drain();

        // Overrun during idx 1, then back-to-back capture on the final beat
        set_matrix(10, 20, 30, 40);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        set_matrix(5, 6, 7, 8);
        step(1'b1, 1'b0);
        check("ovr_pulse", overrun, 1);
        check("ovr_keep", $signed(out_data), 20);
        step(1'b0, 1'b1);
        check("ovr_clear", overrun, 0);
        check("ovr_d2", $signed(out_data), 30);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("b2b_idx", out_idx, 0);
        check("b2b_data", $signed(out_data), 5);
        check("b2b_ovr", overrun, 0);
        drain();

        // Asynchronous reset while idx 2 is presented
        set_matrix(11, 22, 33, 44);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("pre_rst_idx", out_idx, 2);
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_idx", out_idx, 0);
        check("arst_busy", busy, 0);
        check("arst_last", out_last, 0);
        q.delete();
        exp_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_matrix(-3, 4, -5, 6);
        step(1'b1, 1'b1);
        check("post_rst_idx", out_idx, 0);
        check("post_rst_data", $signed(out_data), -3);
        drain();

        // Randomized traffic, with cfg_shift and C_flat changing freely after capture
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NE; k++) begin
                case ($urandom_range(0, 3))
                    0:       v = int'($urandom_range(0, 1048575)) - 524288;
                    1:       v = int'($urandom_range(0, 600)) - 300;
                    2:       v = ($urandom_range(0, 1) != 0) ? 524287 : -524288;
                    default: v = int'($urandom_range(0, 256)) - 128;
                endcase
                cm[k] = v;
            end
            set_matrix(cm[0], cm[1], cm[2], cm[3]);
            cfg_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31))
                                                    : 5'($urandom_range(0, 6));
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tpu_result_drain.md
# tpu_result_drain

Downstream stage of the TPU core. Captures the N×N accumulator matrix `C_flat` when the core pulses `done`, then requantizes each element to `OUT_W` bits. Streams the elements out one per beat, row-major, over a valid/ready interface toward the result writer. While streaming, it holds a private copy of the matrix, so the core can start its next job right away.

## Interface
- `N`, 2, array dimension; matrix has N*N elements
- `ACC_W`, 20, accumulator element width (signed)
- `OUT_W`, 8, output element width (signed); 2 ≤ OUT_W ≤ ACC_W
- `IDX_W`, $clog2(N*N) (min 1), element index width
- `clk`  in  1  clock; all flops rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `c_valid`  in  1  one-cycle pulse: `C_flat` is valid this cycle; connect to core `done`
- `C_flat`  in  N*N*ACC_W  element (i,j) at bits [(i*N+j)*ACC_W +: ACC_W], signed
- `cfg_shift`  in  5  arithmetic right-shift amount; sampled on capture
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  OUT_W  requantized element, signed
- `out_idx`  out  IDX_W  row-major element index i*N+j
- `out_last`  out  1  high on the beat with idx N*N-1
- `out_sat`  out  1  element was clipped; tied 0 when saturation is compiled out
- `busy`  out  1  high in STREAM
- `overrun`  out  1  one-cycle pulse: `c_valid` arrived while busy and was dropped

## Operation
- FSM has two states: IDLE and STREAM. Reset state is IDLE.
- In IDLE, `c_valid` triggers capture:
  - the buffer loads `C_flat`;
  - the shift register loads `cfg_shift`;
  - the index counter resets to 0;
  - the state moves to STREAM.
- In STREAM:
  - `out_valid` is 1;
  - `out_data`, `out_sat` and `out_idx` reflect buffer[idx], requantized;
  - a handshake (`out_valid && out_ready`) increments idx.
- When the handshake completes on idx N*N-1:
  - if `c_valid` is high in the same cycle, the new matrix is captured and STREAM restarts at idx 0, with no bubble and no overrun;
  - otherwise the state returns to IDLE.
- A `c_valid` in STREAM that does not coincide with the final handshake is dropped. The buffer is left unchanged and `overrun` pulses the next cycle.
- Requantization works on each element x:
  - compute y = x >>> shift (sign-extending);
  - shift ≥ ACC_W gives y = 0 or -1 according to sign;
  - y is then narrowed to OUT_W bits as described under Configuration.
- All outputs are decoded from registered state and the buffer. There is no combinational path from `out_ready` to `out_valid`.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `out_sat` 0, `busy` 0, `overrun` 0, state IDLE, buffer 0.
- Capture latency: `c_valid` high in cycle t (IDLE) → `out_valid` = 1 with idx 0 in cycle t+1.
- Throughput: one element per cycle while `out_ready` = 1. A full matrix drains in N*N cycles.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_idx`, `out_last` and `out_sat` hold stable.
- Final handshake in cycle t with no new capture: `out_valid` = 0 and `busy` = 0 in t+1.
- `overrun` is a registered pulse, asserted in the cycle after the dropped `c_valid`.
- Reset mid-stream: asynchronous clear. Outputs drop immediately and the pending matrix is discarded.
- `cfg_shift` changes after capture have no effect on the current matrix.

## Configuration
- Macro: `TPU_RESULT_SAT_EN`.
- Defined:
  - y is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - `out_sat` = 1 when clipping occurred.
- Undefined:
  - `out_data` = y[OUT_W-1:0] (two's-complement wrap);
  - `out_sat` is constant 0.

## Structure
- Shared package `tpu_pkg` holds:
  - the state enumeration (`RD_IDLE`, `RD_STREAM`);
  - the default widths (`TPU_N`, `TPU_W`, `TPU_ACC_W`, `TPU_OUT_W`);
  - a function for the row-major element offset.
- Sub-module `tpu_requant`: combinational shift followed by saturate/truncate. It is parameterised by `ACC_W` and `OUT_W` and instantiated once, on the buffer element selected by idx.
- The top level holds the FSM, index counter, capture buffer and overrun pulse.

## Test plan
All scenarios use N=2, ACC_W=20, OUT_W=8.
- Basic stream: C={1,2,3,4}, shift 0, `out_ready`=1, `c_valid` at t → data 1,2,3,4 and idx 0..3 in cycles t+1..t+4; `out_last` only at t+4; `busy` low at t+5.
- Backpressure: `out_ready` toggling 1,0,0,1,… → each element held stable while stalled, all four delivered in order, no duplicates or losses.
- Shift: C={1000,-1000,7,-7}, shift 3 → 125, -125, 0, -1.
- Saturation: C={300,-300,127,-128}, shift 0:
  - with `TPU_RESULT_SAT_EN`: 127, -128, 127, -128, with `out_sat` = 1,1,0,0;
  - without it: 44, -44, 127, -128, with `out_sat` = 0.
- Overrun and back-to-back:
  - `c_valid` during idx 1 → `overrun` pulse next cycle, original data unchanged;
  - `c_valid` coincident with the final handshake → next matrix starts at idx 0 the following cycle, no `overrun`.
- Reset: assert `rst_n`=0 during idx 2 → all outputs 0 immediately; after release, the next `c_valid` streams normally from idx 0.
